alu_ctrl_exec_unit: RTL and testbench
=====================================

// Module: alu_ctrl_exec_unit
// PURPOSE
//  Parametrised EX-stage ALU control and execute unit. Decodes ALUOp and {funct7,funct3} into a full RV32IM-subset op set.
//  Executes single-cycle ops and an iterative MUL behind a valid/ready handshake.
//  Stalls the pipeline through ready_o while a MUL is in flight.
// PARAMETERS
//  XLEN      32  datapath width in bits; must be a power of two, >= 8
//  MUL_STEP  1   multiplier bits consumed per MUL cycle; XLEN % MUL_STEP == 0
// PORTS
//  clk_i        in   1     clock; all state updates on rising edge
//  rst_i        in   1     synchronous reset, active-high
//  valid_i      in   1     operation presented on the inputs below
//  ready_o      out  1     unit can accept an op this cycle
//  aluop_i      in   2     00 add (ld/st), 01 sub (branch), 10 R-type, 11 I-type
//  func73_i     in   10    {funct7[6:0], funct3[2:0]}
//  src1_i       in   XLEN  operand A
//  src2_i       in   XLEN  operand B (register or sign-extended immediate)
//  valid_o      out  1     result_o / illegal_o valid
//  ready_i      in   1     downstream consumes result this cycle
//  result_o     out  XLEN  registered result
//  illegal_o    out  1     accepted op had an undefined encoding
//  busy_o       out  1     MUL in progress
// BEHAVIOUR
//  Reset: state=IDLE, valid_o=0, result_o=0, illegal_o=0, busy_o=0, step counter=0.
//  Accept = valid_i && ready_o; ready_o = (state==IDLE) && (!valid_o || ready_i).
//  Decode, aluop 00 -> ADD; 01 -> SUB.
//  Decode, aluop 10 by func73_i:
//   0000000_000 ADD; 0100000_000 SUB; 0000000_001 SLL; 0000000_010 SLT; 0000000_011 SLTU.
//   0000000_100 XOR; 0000000_101 SRL; 0100000_101 SRA; 0000000_110 OR; 0000000_111 AND.
//   0000001_000 MUL.
//  Decode, aluop 11 by funct3: 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
//   001 SLLI only when funct7==0000000.
//   101 SRLI when funct7==0000000, SRAI when funct7==0100000.
//  Any other encoding is illegal: result_o=0, illegal_o=1, same timing as a single-cycle op.
//  Width rules:
//   shift amount = src2_i[$clog2(XLEN)-1:0]; SLT/SLTU result is zero-extended 0/1.
//   ADD/SUB wrap modulo 2^XLEN; MUL returns the low XLEN bits of the product (sign-agnostic).
//  FSM IDLE:
//   accept single-cycle op -> next edge result_o, illegal_o loaded, valid_o=1; stay IDLE (latency 1).
//   accept MUL -> latch operands, acc=0, cnt=XLEN/MUL_STEP, busy_o=1, go to MUL.
//  FSM MUL:
//   each cycle adds MUL_STEP shifted partial products, shifts the multiplier, cnt-=1.
//   on the edge where cnt goes 1->0: result_o=acc low XLEN, illegal_o=0, valid_o=1, busy_o=0, go to IDLE.
//   MUL latency = XLEN/MUL_STEP cycles from acceptance to valid_o.
//   Operand inputs are ignored while in MUL; valid_i held high is not accepted.
//  Output hold: valid_o && !ready_i holds result_o/illegal_o stable and ready_o=0.
//   valid_o clears on ready_i unless a new result loads on the same edge.
//  Simultaneous: ready_i && valid_o && accept of a single-cycle op -> new result replaces old; valid_o stays 1.
//  Back-to-back single-cycle ops with ready_i=1 sustain 1 op/cycle.
//  Reset mid-MUL or mid-hold: abort, drop the pending result, return to reset values next edge.
// TESTING
//  T1 aluop=10, func 0000000_000, 5+7, ready_i=1 -> one cycle later valid_o=1, result_o=12, illegal_o=0.
//  T2 aluop=10, func 0100000_101, src1=0x80000000, src2=4 -> result_o=0xF8000000; same with funct7=0 -> 0x08000000.
//  T3 MUL 0xFFFFFFFF*3 (XLEN=32, MUL_STEP=1):
//     busy_o=1 and ready_o=0 for 32 cycles, then valid_o=1, result_o=0xFFFFFFFD.
//     Repeat with MUL_STEP=4 -> latency 8.
//  T4 ready_i=0 after an ADD result -> result_o stable, ready_o=0 for 5 cycles.
//     Raise ready_i together with a new valid_i SLTU(1,2) -> next cycle result_o=1.
//  T5 aluop=11, funct3=001, funct7=0100000 -> illegal_o=1, result_o=0, valid_o=1 after 1 cycle.
//  T6 rst_i=1 at MUL cycle 10 -> next edge busy_o=0, valid_o=0, ready_o=1; a following ADD completes normally.

Source files
------------

// File: rtl/alu_ctrl_exec_unit.sv
// EX-stage ALU: decodes ALUOp/{funct7,funct3}, runs single-cycle ops in one cycle
// and MUL as a shift-add iteration consuming MUL_STEP multiplier bits per cycle.
module alu_ctrl_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      aluop_i,
  input  logic [9:0]      func73_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int SHW    = $clog2(XLEN);
  localparam int NSTEPS = XLEN / MUL_STEP;
  localparam int CW     = $clog2(NSTEPS + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR,  OP_AND, OP_MUL
  } op_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          state, state_nxt;
  op_t             op;
  logic            ill;
  logic            accept, is_mul, mul_done;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]   cnt;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [SHW-1:0]  shamt;

  assign f7    = func73_i[9:3];
  assign f3    = func73_i[2:0];
  assign shamt = src2_i[SHW-1:0];

  // ---------------- decode ----------------
  always_comb begin
    op  = OP_ADD;
    ill = 1'b0;
    case (aluop_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (func73_i)
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_110: op = OP_OR;
          10'b0000000_111: op = OP_AND;
          10'b0000001_000: op = OP_MUL;
          default:         ill = 1'b1;
        endcase
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings
        case (f3)
          3'b000: op = OP_ADD;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b001: begin
            if (f7 == 7'b0000000) op = OP_SLL;
            else                  ill = 1'b1;
          end
          default: begin
            if      (f7 == 7'b0000000) op = OP_SRL;
            else if (f7 == 7'b0100000) op = OP_SRA;
            else                       ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  // ---------------- single-cycle execute ----------------
  always_comb begin
    alu_res = '0;
    if (!ill) begin
      case (op)
        OP_ADD:  alu_res = src1_i + src2_i;
        OP_SUB:  alu_res = src1_i - src2_i;
        OP_SLL:  alu_res = src1_i << shamt;
        OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
        OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
        OP_XOR:  alu_res = src1_i ^ src2_i;
        OP_SRL:  alu_res = src1_i >> shamt;
        OP_SRA:  alu_res = $unsigned($signed(src1_i) >>> shamt);
        OP_OR:   alu_res = src1_i | src2_i;
        OP_AND:  alu_res = src1_i & src2_i;
        default: alu_res = '0;
      endcase
    end
  end

  // partial products for this iteration; multiplicand is pre-shifted each cycle
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      default: if (mul_done)         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state == S_IDLE) && (!valid_o || ready_i);
    busy_o   = (state == S_MUL);
    mul_done = (state == S_MUL) && (cnt == CW'(1));
  end

  assign accept = valid_i && ready_o;
  assign is_mul = (op == OP_MUL) && !ill;

  // ---------------- datapath / output register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      illegal_o <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (accept && is_mul) begin
        mcand  <= src1_i;
        mplier <= src2_i;
        acc    <= '0;
        cnt    <= CW'(NSTEPS);
      end else if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << MUL_STEP;
        mplier <= mplier >> MUL_STEP;
        cnt    <= cnt - CW'(1);
      end

      if (accept && !is_mul) begin
        valid_o   <= 1'b1;
        result_o  <= alu_res;
        illegal_o <= ill;
      end else if (mul_done) begin
        valid_o   <= 1'b1;
        result_o  <= acc_nxt;
        illegal_o <= 1'b0;
      end else if (ready_i) begin
        valid_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec_unit.sv
// Directed bench for alu_ctrl_exec_unit; a MUL_STEP=1 and a MUL_STEP=4 instance share inputs.
module tb_alu_ctrl_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i;
  logic [1:0]  aluop;
  logic [9:0]  func73;
  logic [31:0] src1, src2;
  logic        ready_o, valid_o, illegal_o, busy_o;
  logic [31:0] result_o;
  logic        ready4, valid4, illegal4, busy4;
  logic [31:0] result4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_ctrl_exec_unit #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(aluop), .func73_i(func73), .src1_i(src1), .src2_i(src2),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  alu_ctrl_exec_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready4),
    .aluop_i(aluop), .func73_i(func73), .src1_i(src1), .src2_i(src2),
    .valid_o(valid4), .ready_i(ready_i), .result_o(result4),
    .illegal_o(illegal4), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [9:0] f,
                       input logic [31:0] s1, input logic [31:0] s2);
    valid_i = 1'b1;
    aluop   = a;
    func73  = f;
    src1    = s1;
    src2    = s2;
  endtask

  // one single-cycle op with ready_i=1; leaves valid_i low afterwards
  task automatic run_op(input string tag, input logic [1:0] a, input logic [9:0] f,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] exp, input logic exp_ill);
    drive(a, f, s1, s2);
    tick();
    valid_i = 1'b0;
    chk({tag, ".res"}, result_o, exp);
    chk({tag, ".ill"}, {31'd0, illegal_o}, {31'd0, exp_ill});
    chk({tag, ".vld"}, {31'd0, valid_o}, 32'd1);
  endtask

  int lat1, lat4, busy_cnt;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    aluop = 2'b00; func73 = '0; src1 = '0; src2 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", {31'd0, valid_o},   32'd0);
    chk("rst.res",   result_o,           32'd0);
    chk("rst.ill",   {31'd0, illegal_o}, 32'd0);
    chk("rst.busy",  {31'd0, busy_o},    32'd0);
    chk("rst.ready", {31'd0, ready_o},   32'd1);

    // T1
    run_op("t1_add", 2'b10, 10'b0000000_000, 32'd5, 32'd7, 32'd12, 1'b0);
    tick();
    chk("t1.drain", {31'd0, valid_o}, 32'd0);

    // T2 back-to-back
    run_op("t2_sra", 2'b10, 10'b0100000_101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_op("t2_srl", 2'b10, 10'b0000000_101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);

    run_op("sub_br", 2'b01, 10'h3FF,         32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0);
    run_op("slt",    2'b10, 10'b0000000_010, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    run_op("sltu",   2'b10, 10'b0000000_011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    run_op("addwr",  2'b10, 10'b0000000_000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    run_op("sll",    2'b10, 10'b0000000_001, 32'd1,         32'd33,        32'd2,         1'b0);
    run_op("xori",   2'b11, {7'h7F, 3'b100}, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0);
    run_op("andi",   2'b11, {7'h00, 3'b111}, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0);
    run_op("ori",    2'b11, {7'h15, 3'b110}, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    run_op("slti",   2'b11, {7'h7F, 3'b010}, 32'hFFFF_FFFB, 32'd3,         32'd1,         1'b0);
    run_op("srai",   2'b11, {7'h20, 3'b101}, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0);
    run_op("r_ill",  2'b10, 10'b0000001_001, 32'd9,         32'd9,         32'd0,         1'b1);
    run_op("ld_add", 2'b00, 10'h3FF,         32'd10,        32'd20,        32'd30,        1'b0);
    run_op("and",    2'b10, 10'b0000000_111, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_0F00, 1'b0);
    run_op("or",     2'b10, 10'b0000000_110, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0);
    run_op("srl31",  2'b10, 10'b0000000_101, 32'h8000_0000, 32'd31,        32'd1,         1'b0);
    run_op("sub_r",  2'b10, 10'b0100000_000, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
    run_op("sltiu",  2'b11, {7'h7F, 3'b011}, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0);
    // T5
    run_op("t5_ill", 2'b11, {7'b0100000, 3'b001}, 32'd1,    32'd1,         32'd0,         1'b1);
    run_op("srai_bad", 2'b11, {7'b0000001, 3'b101}, 32'd1,  32'd1,         32'd0,         1'b1);

    // T4 output hold; a new op offered during the hold must not be taken
    run_op("t4_add", 2'b10, 10'b0000000_000, 32'd2, 32'd3, 32'd5, 1'b0);
    ready_i = 1'b0;
    drive(2'b10, 10'b0000000_000, 32'd100, 32'd100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4.hold_res", result_o, 32'd5);
      chk("t4.hold_rdy", {31'd0, ready_o}, 32'd0);
    end
    chk("t4.hold_vld", {31'd0, valid_o}, 32'd1);
    ready_i = 1'b1;
    drive(2'b10, 10'b0000000_011, 32'd1, 32'd2);
    #1;
    chk("t4.rdy_on_ri", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    chk("t4.sltu_res", result_o, 32'd1);
    chk("t4.sltu_vld", {31'd0, valid_o}, 32'd1);
    tick();

    // T3 MUL on both instances; operands changed after acceptance must be ignored
    drive(2'b10, 10'b0000001_000, 32'hFFFF_FFFF, 32'd3);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    src1 = 32'h1234_5678;
    src2 = 32'h0000_0077;
    lat1 = -1; lat4 = -1; busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_o && !ready_o) busy_cnt++;
      if (valid_o && lat1 < 0) lat1 = k;
      if (valid4  && lat4 < 0) lat4 = k;
      tick();
    end
    chk("t3.lat1",    lat1,     32'd32);
    chk("t3.lat4",    lat4,     32'd8);
    chk("t3.busycyc", busy_cnt, 32'd32);
    chk("t3.res1",    result_o, 32'hFFFF_FFFD);
    chk("t3.res4",    result4,  32'hFFFF_FFFD);
    chk("t3.ill",     {31'd0, illegal_o}, 32'd0);
    ready_i = 1'b1;
    tick();
    chk("t3.drain",   {31'd0, valid_o}, 32'd0);

    // T6 reset at MUL cycle 10
    drive(2'b10, 10'b0000001_000, 32'd7, 32'd9);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("t6.busy_pre", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.busy",  {31'd0, busy_o},  32'd0);
    chk("t6.valid", {31'd0, valid_o}, 32'd0);
    chk("t6.ready", {31'd0, ready_o}, 32'd1);
    chk("t6.res",   result_o,         32'd0);
    run_op("t6_add", 2'b10, 10'b0000000_000, 32'd7, 32'd8, 32'd15, 1'b0);

    // reset during an output hold drops the pending result
    ready_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_i = 1'b1;
    chk("rsthold.valid", {31'd0, valid_o}, 32'd0);
    chk("rsthold.res",   result_o,         32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
